// File: rtl/mux_scan_capture.sv
// Steps an 8:1 mux select through every input, waits SETTLE_CYCLES after each change, samples one bit.
// A full scan takes NUM_INPUTS*(SETTLE_CYCLES+1) cycles from the start edge to done; abort cancels with no done.
module mux_scan_capture #(
  parameter int NUM_INPUTS    = 8,
  parameter int SEL_WIDTH     = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mux_out,
  output logic [SEL_WIDTH-1:0]   mux_sel,
  output logic                   mux_enable_n,
  output logic                   busy,
  output logic                   done,
  output logic [0:NUM_INPUTS-1]  data
);

  localparam logic [0:0]           S_IDLE   = 1'b0;
  localparam logic [0:0]           S_SCAN   = 1'b1;
  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_INPUTS - 1);
  localparam logic [3:0]           SETTLE   = 4'(SETTLE_CYCLES);

  logic [0:0]            r_state;
  logic [3:0]            r_wait;
  logic [0:NUM_INPUTS-1] r_shadow;
  logic [0:NUM_INPUTS-1] w_merged;

  // Shadow word with the bit being sampled this edge already in place.
  always_comb begin
    w_merged          = r_shadow;
    w_merged[mux_sel] = mux_out;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wait       <= 4'd0;
      r_shadow     <= '0;
      mux_sel      <= '0;
      mux_enable_n <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      data         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            r_state      <= S_SCAN;
            mux_sel      <= '0;
            mux_enable_n <= 1'b0;
            busy         <= 1'b1;
            r_wait       <= SETTLE;
            r_shadow     <= '0;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_state      <= S_IDLE;
            mux_sel      <= '0;
            mux_enable_n <= 1'b1;
            busy         <= 1'b0;
          end else if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_shadow <= w_merged;
            if (mux_sel == LAST_SEL) begin
              data         <= w_merged;
              done         <= 1'b1;
              busy         <= 1'b0;
              mux_enable_n <= 1'b1;
              mux_sel      <= '0;
              r_state      <= S_IDLE;
            end else begin
              mux_sel <= mux_sel + SEL_WIDTH'(1);
              r_wait  <= SETTLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_capture.sv
// Bench for mux_scan_capture: two instances (settle 1 and settle 0), each driving a behavioural 8:1 mux.
module tb_mux_scan_capture;

  logic       clock = 1'b0;
  logic       reset;
  logic       start1, abort1, start0, abort0;
  logic [0:7] in1, in0;
  logic [2:0] sel1, sel0;
  logic       en1_n, en0_n, busy1, busy0, done1, done0, mo1, mo0;
  logic [0:7] data1, data0;

  int n_cmp = 0;
  int n_err = 0;
  int n_edge = 0;

  always #5 clock = ~clock;

  // 74151-style mux: output held low while disabled.
  assign mo1 = en1_n ? 1'b0 : in1[sel1];
  assign mo0 = en0_n ? 1'b0 : in0[sel0];

  mux_scan_capture #(.NUM_INPUTS(8), .SEL_WIDTH(3), .SETTLE_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1), .mux_out(mo1),
    .mux_sel(sel1), .mux_enable_n(en1_n), .busy(busy1), .done(done1), .data(data1));

  mux_scan_capture #(.NUM_INPUTS(8), .SEL_WIDTH(3), .SETTLE_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort0), .mux_out(mo0),
    .mux_sel(sel0), .mux_enable_n(en0_n), .busy(busy0), .done(done0), .data(data0));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model for the settle-1 instance, built from the timing rule:
  // bit k is taken (k+1)*2 edges after the start edge, done after 16 edges.
  bit         m_on = 0;
  bit         m_busy, m_done;
  int         m_t0;
  logic [0:7] m_cap, m_data;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_t0 = 0; m_cap = '0; m_data = '0;
  endtask

  task automatic model_tick();
    int t, k, exp_sel;
    m_done = 0;
    if (!m_busy) begin
      if (start1 && !abort1) begin
        m_busy = 1; m_t0 = n_edge; m_cap = '0;
      end
    end else if (abort1) begin
      m_busy = 0;
    end else begin
      t = n_edge - m_t0;
      if (t % 2 == 0) begin
        k = t / 2 - 1;
        m_cap[k] = in1[k];
        if (k == 7) begin
          m_data = m_cap; m_done = 1; m_busy = 0;
        end
      end
    end
    exp_sel = m_busy ? (n_edge - m_t0) / 2 : 0;
    check("rnd_busy", int'(busy1), int'(m_busy));
    check("rnd_done", int'(done1), int'(m_done));
    check("rnd_en_n", int'(en1_n), int'(!m_busy));
    check("rnd_sel", int'(sel1), exp_sel);
    check("rnd_data", int'(data1), int'(m_data));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    n_edge++;
    if (m_on) model_tick();
  endtask

  // Pulse start on the chosen instance, then count edges to done (bounded).
  task automatic run_scan(input bit w0, input logic [0:7] v, output int lat,
                          output int bcnt, output logic [0:7] d);
    bit got;
    if (w0) begin in0 = v; start0 = 1'b1; end
    else begin in1 = v; start1 = 1'b1; end
    step();
    start0 = 1'b0; start1 = 1'b0;
    bcnt = (w0 ? busy0 : busy1) ? 1 : 0;
    lat = -1; got = 0; d = '0;
    for (int i = 1; i <= 100 && !got; i++) begin
      step();
      if (w0 ? done0 : done1) begin
        got = 1; lat = i; d = w0 ? data0 : data1;
      end else if (w0 ? busy0 : busy1) begin
        bcnt++;
      end
    end
  endtask

  typedef struct {
    bit         w0;
    logic [0:7] inputs;
    logic [0:7] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         lat, bcnt, cnt;
    logic [0:7] d;

    vecs[0] = '{1'b0, 8'b10110010, 8'b10110010, 16};
    vecs[1] = '{1'b1, 8'b01000001, 8'b01000001, 8};
    vecs[2] = '{1'b0, 8'b11111111, 8'b11111111, 16};
    vecs[3] = '{1'b1, 8'b10000000, 8'b10000000, 8};
    vecs[4] = '{1'b0, 8'b00000001, 8'b00000001, 16};

    reset = 1'b1; start1 = 0; abort1 = 0; start0 = 0; abort0 = 0; in1 = '0; in0 = '0;
    #12;
    check("rst_sel", int'(sel1), 0);
    check("rst_en_n", int'(en1_n), 1);
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_data", int'(data1), 0);
    reset = 1'b0;
    step();

    // Table: basic scans on both instances.
    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].w0, vecs[i].inputs, lat, bcnt, d);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_lat);
      check($sformatf("vec%0d_data", i), int'(d), int'(vecs[i].exp_data));
      step();
      check($sformatf("vec%0d_done_falls", i), int'(vecs[i].w0 ? done0 : done1), 0);
    end

    // Settle 0: select walks 0..7 on consecutive cycles.
    in0 = 8'b01000001; start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("s0_sel%0d", k), int'(sel0), k);
      step();
    end
    check("s0_done", int'(done0), 1);
    check("s0_data", int'(data0), int'(8'b01000001));

    // Inputs drop after bit 3 is sampled (edge 8 after start).
    in1 = 8'hFF; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (8) step();
    in1 = 8'h00;
    cnt = 0;
    while (!done1 && cnt < 40) begin step(); cnt++; end
    check("chg_lat", cnt + 8, 16);
    check("chg_data", int'(data1), int'(8'b11110000));

    // Abort at cycle 6 of a scan following a 10110010 scan.
    run_scan(1'b0, 8'b10110010, lat, bcnt, d);
    check("pre_abort_data", int'(d), int'(8'b10110010));
    in1 = 8'b01010101; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (5) step();
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    check("abort_busy", int'(busy1), 0);
    check("abort_en_n", int'(en1_n), 1);
    check("abort_sel", int'(sel1), 0);
    cnt = 0;
    repeat (20) begin step(); if (done1) cnt++; end
    check("abort_no_done", cnt, 0);
    check("abort_data", int'(data1), int'(8'b10110010));

    // Abort in idle blocks a simultaneous start.
    start1 = 1'b1; abort1 = 1'b1;
    step();
    start1 = 1'b0; abort1 = 1'b0;
    check("idle_abort_blocks", int'(busy1), 0);

    // Start held high: back-to-back scans, 16 then 17 edges between dones.
    in1 = 8'b00110101; start1 = 1'b1;
    step();
    cnt = 0;
    while (!done1 && cnt < 40) begin step(); cnt++; end
    check("b2b_first_lat", cnt, 16);
    check("b2b_first_data", int'(data1), int'(8'b00110101));
    in1 = 8'b11000011;
    step();
    check("b2b_done_falls", int'(done1), 0);
    check("b2b_busy_rises", int'(busy1), 1);
    cnt = 1;
    while (!done1 && cnt < 40) begin step(); cnt++; end
    start1 = 1'b0;
    check("b2b_period", cnt, 17);
    check("b2b_second_data", int'(data1), int'(8'b11000011));
    repeat (3) step();

    // Asynchronous reset in the middle of cycle 5 of a scan.
    in1 = 8'b11001100; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy1), 0);
    check("mid_rst_en_n", int'(en1_n), 1);
    check("mid_rst_sel", int'(sel1), 0);
    check("mid_rst_data", int'(data1), 0);
    check("mid_rst_done", int'(done1), 0);
    #2 reset = 1'b0;
    run_scan(1'b0, 8'b00111100, lat, bcnt, d);
    check("post_rst_lat", lat, 16);
    check("post_rst_data", int'(d), int'(8'b00111100));

    // Randomised traffic against the model.
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    m_on = 1;
    for (int c = 0; c < 1500; c++) begin
      start1 = ($urandom % 4) == 0;
      abort1 = ($urandom % 40) == 0;
      in1    = 8'($urandom);
      step();
    end
    m_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
